zone_stat: RTL

ZONE_STAT -- requirements
Module: zone_stat

---
 rtl/zone_stat.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/zone_stat.sv
// Per-zone luminance statistic (max or mean) over a grid of zones; each completed
// zone row is snapshotted and emitted one zone per cycle.
module zone_stat #(
  parameter int PIX_W     = 8,
  parameter int ZONES_H   = 8,
  parameter int ZONES_V   = 4,
  parameter int ZONE_W    = 240,
  parameter int ZONE_H    = 270,
  parameter int AVG_SHIFT = 16
) (
  input  logic                                         iODCK,
  input  logic                                         iRST,
  input  logic                                         iV_Duty,
  input  logic                                         iH_Duty,
  input  logic [PIX_W-1:0]                             iPixelData,
  input  logic                                         iMode,
  output logic [PIX_W-1:0]                             oZoneData,
  output logic                                         oZoneValid,
  output logic [5:0]                                   oZoneCol,
  output logic [$clog2(ZONES_V > 1 ? ZONES_V : 2)-1:0] oZoneRow,
  output logic                                         oOverrun
);

  localparam int ACC_W  = PIX_W + AVG_SHIFT;
  localparam int ROW_W  = $clog2(ZONES_V > 1 ? ZONES_V : 2);
  localparam int COL_W  = $clog2(ZONES_H + 1);
  localparam int IN_W   = $clog2(ZONE_W + 1);
  localparam int LINE_W = $clog2(ZONE_H + 1);
  localparam int BIX_W  = $clog2(ZONES_H > 1 ? ZONES_H : 2);

  localparam logic [COL_W-1:0]  NCOLS     = COL_W'(ZONES_H);
  localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(ZONE_W - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ZONE_H - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ZONES_V - 1);
  localparam logic [5:0]        EMIT_LAST = 6'(ZONES_H - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  function automatic logic [ACC_W-1:0] accUpdate(input logic [ACC_W-1:0] acc,
                                                 input logic [PIX_W-1:0] pix,
                                                 input logic meanMode);
    logic [ACC_W-1:0] pixW;
    pixW = ACC_W'(pix);
    if (meanMode) return acc + pixW;
    return (pixW > acc) ? pixW : acc;
  endfunction

  function automatic logic [PIX_W-1:0] zoneValue(input logic [ACC_W-1:0] acc,
                                                 input logic meanMode);
    if (meanMode) return PIX_W'(acc >> AVG_SHIFT);
    return PIX_W'(acc);
  endfunction

  logic              hDuty_p0, vDuty_p0, frameOn, modeReg, rowsDone;
  logic [COL_W-1:0]  colCnt;
  logic [IN_W-1:0]   inCnt;
  logic [LINE_W-1:0] lineCnt;
  logic [ROW_W-1:0]  rowCnt;

  logic              vStart, active, modeEff, hRise, pixAccept, lineEnd, snapshot;
  logic [COL_W-1:0]  curCol;
  logic [IN_W-1:0]   curIn;

  logic [ACC_W-1:0]  acc_p0 [ZONES_H];
  logic [PIX_W-1:0]  bank_p1 [ZONES_H];
  logic [0:0]        emitState;
  logic [5:0]        emitCol;
  logic [ROW_W-1:0]  emitRow;
  logic              overrun;

  // The reset value of vDuty_p0 is high so that a frame already in progress at
  // reset release is skipped; processing starts at the next genuine iV_Duty rise.
  always_comb begin
    vStart    = iV_Duty & ~vDuty_p0;
    active    = iV_Duty & (frameOn | vStart) & ~rowsDone;
    modeEff   = vStart ? iMode : modeReg;
    hRise     = iH_Duty & ~hDuty_p0;
    curCol    = hRise ? '0 : colCnt;
    curIn     = hRise ? '0 : inCnt;
    pixAccept = active & iH_Duty & (curCol < NCOLS);
    lineEnd   = active & hDuty_p0 & ~iH_Duty;
    snapshot  = lineEnd & (lineCnt == LINE_LAST);
  end

  // Stage p0: line/zone bookkeeping
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      hDuty_p0 <= 1'b0;
      vDuty_p0 <= 1'b1;
      frameOn  <= 1'b0;
      modeReg  <= 1'b0;
      rowsDone <= 1'b0;
      colCnt   <= '0;
      inCnt    <= '0;
      lineCnt  <= '0;
      rowCnt   <= '0;
    end else begin
      hDuty_p0 <= iH_Duty;
      vDuty_p0 <= iV_Duty;
      if (!iV_Duty) begin
        frameOn  <= 1'b0;
        rowsDone <= 1'b0;
        colCnt   <= '0;
        inCnt    <= '0;
        lineCnt  <= '0;
        rowCnt   <= '0;
      end else begin
        if (vStart) begin
          frameOn <= 1'b1;
          modeReg <= iMode;
        end
        if (iH_Duty) begin
          if (curIn == IN_LAST) begin
            inCnt  <= '0;
            colCnt <= (curCol != NCOLS) ? curCol + 1'b1 : curCol;
          end else begin
            inCnt  <= curIn + 1'b1;
            colCnt <= curCol;
          end
        end
        if (lineEnd) begin
          if (snapshot) begin
            lineCnt <= '0;
            if (rowCnt == ROW_LAST) rowsDone <= 1'b1;
            else                    rowCnt   <= rowCnt + 1'b1;
          end else begin
            lineCnt <= lineCnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      for (int c = 0; c < ZONES_H; c++) acc_p0[c] <= '0;
    end else begin
      for (int c = 0; c < ZONES_H; c++) begin
        if (!iV_Duty || snapshot)
          acc_p0[c] <= '0;
        else if (pixAccept && (curCol == COL_W'(c)))
          acc_p0[c] <= accUpdate(acc_p0[c], iPixelData, modeEff);
      end
    end
  end

  // Stage p1: output bank and emission FSM
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      for (int c = 0; c < ZONES_H; c++) bank_p1[c] <= '0;
      emitState <= IDLE;
      emitCol   <= '0;
      emitRow   <= '0;
      overrun   <= 1'b0;
    end else if (snapshot) begin
      for (int c = 0; c < ZONES_H; c++) bank_p1[c] <= zoneValue(acc_p0[c], modeEff);
      if (emitState == EMIT) overrun <= 1'b1;
      emitState <= EMIT;
      emitCol   <= '0;
      emitRow   <= rowCnt;
    end else if (emitState == EMIT) begin
      if (emitCol == EMIT_LAST) emitState <= IDLE;
      else                      emitCol   <= emitCol + 1'b1;
    end
  end

  // emitCol parks on the last column, so data and column hold between rows.
  assign oZoneValid = (emitState == EMIT);
  assign oZoneCol   = emitCol;
  assign oZoneRow   = emitRow;
  assign oZoneData  = bank_p1[emitCol[BIX_W-1:0]];
  assign oOverrun   = overrun;

endmodule
